// File: rtl/decode_if.sv
// Handshake and data bundle between the IF/ID register, write-back, EX and the decode stage.
// slave = the decode stage itself, master = whatever drives its inputs.
interface decode_if #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc_plus4;
   logic             wb_we;
   logic [AW-1:0]    wb_waddr;
   logic [XLEN-1:0]  wb_wdata;
   logic             ex_mem_read;
   logic [AW-1:0]    ex_rt;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [5:0]       out_opcode;
   logic [5:0]       out_funct;
   logic [4:0]       out_shamt;
   logic [AW-1:0]    out_rs;
   logic [AW-1:0]    out_rt;
   logic [AW-1:0]    out_rd;
   logic [XLEN-1:0]  out_rs_val;
   logic [XLEN-1:0]  out_rt_val;
   logic [XLEN-1:0]  out_imm_ext;
   logic [XLEN-1:0]  out_jump_target;
   logic [XLEN-1:0]  out_pc_plus4;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output in_valid, in_instr, in_pc_plus4, wb_we, wb_waddr, wb_wdata,
             ex_mem_read, ex_rt, flush, out_ready,
      input  in_ready, out_valid, out_opcode, out_funct, out_shamt, out_rs, out_rt,
             out_rd, out_rs_val, out_rt_val, out_imm_ext, out_jump_target,
             out_pc_plus4, stall_cnt
   );

   modport slave (
      input  in_valid, in_instr, in_pc_plus4, wb_we, wb_waddr, wb_wdata,
             ex_mem_read, ex_rt, flush, out_ready,
      output in_ready, out_valid, out_opcode, out_funct, out_shamt, out_rs, out_rt,
             out_rd, out_rs_val, out_rt_val, out_imm_ext, out_jump_target,
             out_pc_plus4, stall_cnt
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file with write-back bypass, field/immediate decode,
// load-use interlock, flush and ID/EX output register. Optional macro: DECODE_HOLD_REFRESH_EN.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int CNT_W = 16
) (
   input logic      clk,
   input logic      rst_n,
   decode_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   function automatic logic [AW-1:0] fld(input logic [4:0] f);
      logic [AW+4:0] ext;
      ext = {{AW{1'b0}}, f};
      return ext[AW-1:0];
   endfunction

   function automatic logic [XLEN-1:0] imm_extend(input logic [5:0] op, input logic [15:0] imm);
      logic [XLEN-1:0]        zx;
      logic signed [XLEN-1:0] sx;
      zx = {{(XLEN-16){1'b0}}, imm};
      sx = {{(XLEN-16){imm[15]}}, imm};
      case (op)
         6'h0C, 6'h0D, 6'h0E: return zx;
         6'h0F:               return zx << 16;
         default:             return sx;
      endcase
   endfunction

   logic [XLEN-1:0]  rf_q [NREG];
   logic             wb_hit;
   logic [31:0]      instr;
   logic [5:0]       opcode_d, funct_d;
   logic [4:0]       shamt_d;
   logic [AW-1:0]    rs_d, rt_d, rd_d;
   logic [XLEN-1:0]  rs_val_d, rt_val_d, imm_d, jt_d;
   logic             hazard, advance, in_ready;

   logic             out_valid_q;
   logic [5:0]       opcode_q, funct_q;
   logic [4:0]       shamt_q;
   logic [AW-1:0]    rs_q, rt_q, rd_q;
   logic [XLEN-1:0]  rs_val_q, rt_val_q, imm_q, jt_q, pc4_q;
   logic [CNT_W-1:0] cnt_q;

   assign instr    = bus.in_instr;
   assign wb_hit   = bus.wb_we && (bus.wb_waddr != '0);
   assign opcode_d = instr[31:26];
   assign funct_d  = instr[5:0];
   assign shamt_d  = instr[10:6];
   assign rs_d     = fld(instr[25:21]);
   assign rt_d     = fld(instr[20:16]);
   assign rd_d     = fld(instr[15:11]);
   assign imm_d    = imm_extend(instr[31:26], instr[15:0]);
   assign jt_d     = {bus.in_pc_plus4[XLEN-1:28], instr[25:0], 2'b00};

   // Same-cycle write-back is forwarded so the reader never sees the stale entry
   always_comb begin
      rs_val_d = rf_q[rs_d];
      rt_val_d = rf_q[rt_d];
      if (wb_hit && bus.wb_waddr == rs_d) rs_val_d = bus.wb_wdata;
      if (wb_hit && bus.wb_waddr == rt_d) rt_val_d = bus.wb_wdata;
      if (rs_d == '0) rs_val_d = '0;
      if (rt_d == '0) rt_val_d = '0;
   end

   assign hazard   = bus.in_valid && bus.ex_mem_read && (bus.ex_rt != '0) &&
                     ((bus.ex_rt == rs_d) || (bus.ex_rt == rt_d));
   assign advance  = !out_valid_q || bus.out_ready;
   assign in_ready = bus.flush || (advance && !hazard);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_hit) begin
         rf_q[bus.wb_waddr] <= bus.wb_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         shamt_q     <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         rs_val_q    <= '0;
         rt_val_q    <= '0;
         imm_q       <= '0;
         jt_q        <= '0;
         pc4_q       <= '0;
      end else if (bus.flush) begin
         out_valid_q <= 1'b0;
      end else if (hazard && advance) begin
         out_valid_q <= 1'b0;
      end else if (bus.in_valid && in_ready) begin
         out_valid_q <= 1'b1;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         shamt_q     <= shamt_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         rs_val_q    <= rs_val_d;
         rt_val_q    <= rt_val_d;
         imm_q       <= imm_d;
         jt_q        <= jt_d;
         pc4_q       <= bus.in_pc_plus4;
      end else if (advance && !bus.in_valid) begin
         out_valid_q <= 1'b0;
      end else begin
`ifdef DECODE_HOLD_REFRESH_EN
         // Held operands track write-back so EX sees the current value on release
         if (wb_hit && bus.wb_waddr == rs_q) rs_val_q <= bus.wb_wdata;
         if (wb_hit && bus.wb_waddr == rt_q) rt_val_q <= bus.wb_wdata;
`else
         out_valid_q <= out_valid_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (hazard && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.in_ready        = in_ready;
   assign bus.out_valid       = out_valid_q;
   assign bus.out_opcode      = opcode_q;
   assign bus.out_funct       = funct_q;
   assign bus.out_shamt       = shamt_q;
   assign bus.out_rs          = rs_q;
   assign bus.out_rt          = rt_q;
   assign bus.out_rd          = rd_q;
   assign bus.out_rs_val      = rs_val_q;
   assign bus.out_rt_val      = rt_val_q;
   assign bus.out_imm_ext     = imm_q;
   assign bus.out_jump_target = jt_q;
   assign bus.out_pc_plus4    = pc4_q;
   assign bus.stall_cnt       = cnt_q;
endmodule
